// File: rtl/pb_pkg.sv
// Shared types and helpers for the push-button debounce array.
package pb_pkg;

    typedef enum logic [1:0] {
        PB_IDLE  = 2'd0,
        PB_PRESS = 2'd1,
        PB_HELD  = 2'd2
    } pb_state_t;

    // Bits needed to hold the values 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pb_channel.sv
// One button channel: synchroniser, debounce filter and press/hold/repeat FSM.
module pb_channel
    import pb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DB_CYCLES     = 1000,
    parameter int unsigned HOLD_CYCLES   = 50000,
    parameter int unsigned REPEAT_CYCLES = 10000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    input  logic en,
    output logic level,
    output logic pressed,
    output logic released,
    output logic held,
    output logic repeat_o
);

    localparam int unsigned DB_W     = cnt_w(DB_CYCLES);
    localparam int unsigned HOLD_W   = cnt_w(HOLD_CYCLES);
    localparam int unsigned REP_W    = (REPEAT_CYCLES == 0) ? 1 : cnt_w(REPEAT_CYCLES);
    localparam int unsigned REP_LAST = (REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1;
    localparam logic        IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] sync;
    logic [DB_W-1:0]        db_cnt;
    logic [HOLD_W-1:0]      hold_cnt, hold_nx;
    logic [REP_W-1:0]       rep_cnt, rep_nx;
    pb_state_t              state, state_nx;
    logic                   pressed_nx, released_nx, held_nx, repeat_nx;
    logic                   s_c, accept_c, rise_c, fall_c;

    // Raw pin goes straight into the first flop; presets to the idle pin level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{IDLE_PIN}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pb};
        end
    end

    assign s_c      = sync[SYNC_STAGES-1] ^ IDLE_PIN;
    assign accept_c = (s_c != level) && (db_cnt == DB_W'(DB_CYCLES - 1));
    assign rise_c   = accept_c & s_c;
    assign fall_c   = accept_c & ~s_c;

    // Debounce: a new level must persist DB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (s_c != level) begin
            if (accept_c) begin
                level  <= s_c;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Hold FSM next state; strobes react to the accept edge so they align with level.
    always_comb begin
        state_nx    = state;
        hold_nx     = hold_cnt;
        rep_nx      = rep_cnt;
        pressed_nx  = 1'b0;
        released_nx = 1'b0;
        held_nx     = 1'b0;
        repeat_nx   = 1'b0;
        if (!en) begin
            state_nx = PB_IDLE;
            hold_nx  = '0;
            rep_nx   = '0;
        end else begin
            case (state)
                PB_IDLE: begin
                    if (rise_c) begin
                        state_nx   = PB_PRESS;
                        pressed_nx = 1'b1;
                        hold_nx    = '0;
                    end
                end
                PB_PRESS: begin
                    if (fall_c) begin
                        state_nx    = PB_IDLE;
                        released_nx = 1'b1;
                        hold_nx     = '0;
                    end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state_nx = PB_HELD;
                        held_nx  = 1'b1;
                        rep_nx   = '0;
                    end else begin
                        hold_nx = hold_cnt + HOLD_W'(1);
                    end
                end
                PB_HELD: begin
                    if (fall_c) begin
                        state_nx    = PB_IDLE;
                        released_nx = 1'b1;
                        hold_nx     = '0;
                        rep_nx      = '0;
                    end else if (REPEAT_CYCLES != 0) begin
                        if (rep_cnt == REP_W'(REP_LAST)) begin
                            repeat_nx = 1'b1;
                            rep_nx    = '0;
                        end else begin
                            rep_nx = rep_cnt + REP_W'(1);
                        end
                    end
                end
                default: begin
                    state_nx = PB_IDLE;
                    hold_nx  = '0;
                    rep_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PB_IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            pressed  <= 1'b0;
            released <= 1'b0;
            held     <= 1'b0;
            repeat_o <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            rep_cnt  <= rep_nx;
            pressed  <= pressed_nx;
            released <= released_nx;
            held     <= held_nx;
            repeat_o <= repeat_nx;
        end
    end

endmodule

// File: rtl/pb_debounce_array.sv
// N-channel push-button front end: one independent debounce/hold channel per pin.
module pb_debounce_array
    import pb_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DB_CYCLES     = 1000,
    parameter int unsigned HOLD_CYCLES   = 50000,
    parameter int unsigned REPEAT_CYCLES = 10000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb,
    input  logic            en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] released,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] repeat_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pb_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .pb      (pb[i]),
            .en      (en),
            .level   (level[i]),
            .pressed (pressed[i]),
            .released(released[i]),
            .held    (held[i]),
            .repeat_o(repeat_o[i])
        );
    end

endmodule
